regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the pipelined RISC-V core. It provides NRD combinational read ports, two clocked write ports, x0 hardwired to zero, write-to-read bypass, and a reset that clears every register. It also holds a per-register busy scoreboard, set at issue and cleared at writeback, which the hazard unit uses to stall decode.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/regfile_sb.sv | 67 ++++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the integer register file, decode and hazard units.
//   XLEN_DEF  : default integer data width
//   NREGS_DEF : default number of architectural registers
//   REG_ZERO  : index of the hardwired-zero register x0
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned REG_ZERO  = '0;

endpackage

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Per-register busy scoreboard. A bit is set when an instruction issues with
// that destination and cleared when a write port writes back to it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears every bit)
//   iss_v      : issue valid, marks iss_a busy
//   iss_a      : destination register of the issuing instruction
//   flush      : clears the whole scoreboard, overrides a same-edge issue
//   we, wa     : the two register-file write ports (enables / packed addrs)
//   ra         : packed read addresses, one per read port
//   rbusy      : busy flag per read port, masked by a same-cycle write
// -----------------------------------------------------------------------------
module regfile_sb
   import riscv_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          iss_v,
   input  logic [$clog2(NREGS)-1:0]      iss_a,
   input  logic                          flush,
   input  logic [1:0]                    we,
   input  logic [2*$clog2(NREGS)-1:0]    wa,
   input  logic [NRD*$clog2(NREGS)-1:0]  ra,
   output logic [NRD-1:0]                rbusy
);

   localparam int AW = $clog2(NREGS);

   logic [NREGS-1:0] sb;
   logic [NREGS-1:0] sb_next;
   logic [AW-1:0]    wa0;
   logic [AW-1:0]    wa1;

   assign wa0 = wa[0  +: AW];
   assign wa1 = wa[AW +: AW];

   // Writeback clears first so a same-cycle issue to the same register
   // re-sets the bit; flush then overrides everything.
   always_comb begin
      sb_next = sb;
      if (we[0]) sb_next[wa0] = 1'b0;
      if (we[1]) sb_next[wa1] = 1'b0;
      if (iss_v && (iss_a != AW'(REG_ZERO))) sb_next[iss_a] = 1'b1;
      if (flush) sb_next = '0;
      sb_next[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sb <= '0;
      else        sb <= sb_next;
   end

   // A register being written this cycle is served by the bypass, so it is
   // never reported busy to the hazard unit.
   for (genvar i = 0; i < NRD; i++) begin : g_busy
      logic [AW-1:0] a;
      logic          wr_hit;
      assign a      = ra[i*AW +: AW];
      assign wr_hit = (we[0] && (wa0 == a)) || (we[1] && (wa1 == a));
      assign rbusy[i] = sb[a] && !wr_hit;
   end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file: NRD combinational read ports with
// write-to-read bypass, two clocked write ports (port 1 wins a collision),
// x0 hardwired to zero, and a busy scoreboard for the hazard unit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all state)
//   ra / rd    : packed read addresses / read data, port i at slice i
//   rbusy      : scoreboard busy flag per read port
//   we, wa, wd : two write ports (enables, packed addresses, packed data)
//   iss_v/a    : issue valid and destination register (sets busy)
//   flush      : clears the scoreboard
// -----------------------------------------------------------------------------
module regfile_mp
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NRD*$clog2(NREGS)-1:0]  ra,
   output logic [NRD*XLEN-1:0]           rd,
   output logic [NRD-1:0]                rbusy,
   input  logic [1:0]                    we,
   input  logic [2*$clog2(NREGS)-1:0]    wa,
   input  logic [2*XLEN-1:0]             wd,
   input  logic                          iss_v,
   input  logic [$clog2(NREGS)-1:0]      iss_a,
   input  logic                          flush
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] regs [NREGS];
   logic [AW-1:0]   wa0, wa1;
   logic [XLEN-1:0] wd0, wd1;

   assign wa0 = wa[0    +: AW];
   assign wa1 = wa[AW   +: AW];
   assign wd0 = wd[0    +: XLEN];
   assign wd1 = wd[XLEN +: XLEN];

   // regs[0] is only ever loaded by reset, so it stays zero. Port 1 is
   // assigned after port 0 so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NREGS; j++) regs[j] <= '0;
      end else begin
         if (we[0] && (wa0 != AW'(REG_ZERO))) regs[wa0] <= wd0;
         if (we[1] && (wa1 != AW'(REG_ZERO))) regs[wa1] <= wd1;
      end
   end

   // Read ports: x0 and reset force zero; otherwise bypass the pending write
   // (port 1 first, matching the write priority) before the stored value.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] val;
      assign a = ra[i*AW +: AW];
      always_comb begin
         val = '0;
         if (rst_n && (a != AW'(REG_ZERO))) begin
            if (we[1] && (wa1 == a))      val = wd1;
            else if (we[0] && (wa0 == a)) val = wd0;
            else                          val = regs[a];
         end
      end
      assign rd[i*XLEN +: XLEN] = val;
   end

   regfile_sb #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_sb (
      .clk   (clk),
      .rst_n (rst_n),
      .iss_v (iss_v),
      .iss_a (iss_a),
      .flush (flush),
      .we    (we),
      .wa    (wa),
      .ra    (ra),
      .rbusy (rbusy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic                 clk;
   logic                 rst_n;
   logic [NRD*AW-1:0]    ra;
   logic [NRD*XLEN-1:0]  rd;
   logic [NRD-1:0]       rbusy;
   logic [1:0]           we;
   logic [2*AW-1:0]      wa;
   logic [2*XLEN-1:0]    wd;
   logic                 iss_v;
   logic [AW-1:0]        iss_a;
   logic                 flush;

   logic [AW-1:0]   ra0, ra1, wa0, wa1;
   logic [XLEN-1:0] wd0, wd1;

   assign ra = {ra1, ra0};
   assign wa = {wa1, wa0};
   assign wd = {wd1, wd0};

   int n_cmp = 0;
   int n_err = 0;

   regfile_mp #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ra    (ra),
      .rd    (rd),
      .rbusy (rbusy),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .iss_v (iss_v),
      .iss_a (iss_a),
      .flush (flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rd0();
      return rd[0 +: XLEN];
   endfunction

   function automatic logic [31:0] rd1();
      return rd[XLEN +: XLEN];
   endfunction

   function automatic logic [31:0] busy(input int i);
      return {31'b0, rbusy[i]};
   endfunction

   initial begin
      rst_n = 1'b0;
      ra0 = 5'd1; ra1 = 5'd0;
      we = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      iss_v = 1'b0; iss_a = '0; flush = 1'b0;

      // Reset state
      #2;
      check("reset_rd0", rd0(), 32'h0);
      check("reset_rbusy", {30'b0, rbusy}, 32'h0);
      #10;
      rst_n = 1'b1;          // t=12, between edges
      tick();                // t=16

      // Write x1 and read back (bypass before edge, storage after)
      we = 2'b01; wa0 = 5'd1; wd0 = 32'hDEADBEEF;
      #1;
      check("wr_bypass_x1", rd0(), 32'hDEADBEEF);
      tick();
      we = 2'b00;
      #1;
      check("rdback_x1", rd0(), 32'hDEADBEEF);
      check("rdback_x0", rd1(), 32'h0);

      // Mark x1 busy, then reset mid-cycle with a pending write to x2
      iss_v = 1'b1; iss_a = 5'd1;
      tick();
      iss_v = 1'b0;
      #1;
      check("busy_x1", busy(0), 32'h1);
      #1;
      rst_n = 1'b0;
      we = 2'b01; wa0 = 5'd2; wd0 = 32'h55AA55AA; ra1 = 5'd2;
      #1;
      check("rst_rd_x1", rd0(), 32'h0);
      check("rst_rbusy_x1", busy(0), 32'h0);
      check("rst_no_bypass", rd1(), 32'h0);
      tick();                // edge while in reset: write ignored
      rst_n = 1'b1;
      we = 2'b00;
      #1;
      check("post_rst_x1", rd0(), 32'h0);
      check("post_rst_x2", rd1(), 32'h0);
      check("post_rst_busy", busy(0), 32'h0);
      tick();

      // Bypass on read port 1
      we = 2'b01; wa0 = 5'd5; wd0 = 32'h12345678; ra1 = 5'd5;
      #1;
      check("bypass_x5", rd1(), 32'h12345678);
      tick();
      we = 2'b00;
      #1;
      check("stored_x5", rd1(), 32'h12345678);

      // Write collision on x7: port 1 wins
      we = 2'b11; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h1111; wd1 = 32'h2222; ra0 = 5'd7;
      #1;
      check("coll_bypass_x7", rd0(), 32'h2222);
      tick();
      we = 2'b00;
      #1;
      check("coll_stored_x7", rd0(), 32'h2222);

      // Distinct addresses on both ports in one edge
      we = 2'b11; wa0 = 5'd10; wa1 = 5'd11; wd0 = 32'hA0A0A0A0; wd1 = 32'hB1B1B1B1;
      tick();
      we = 2'b00; ra0 = 5'd10; ra1 = 5'd11;
      #1;
      check("dual_x10", rd0(), 32'hA0A0A0A0);
      check("dual_x11", rd1(), 32'hB1B1B1B1);

      // x0 protection
      we = 2'b10; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra0 = 5'd0;
      #1;
      check("x0_no_bypass", rd0(), 32'h0);
      tick();
      we = 2'b00;
      #1;
      check("x0_stays_zero", rd0(), 32'h0);

      // Scoreboard set / same-cycle clear
      iss_v = 1'b1; iss_a = 5'd3;
      tick();
      iss_v = 1'b0; ra0 = 5'd3;
      #1;
      check("sb_set_x3", busy(0), 32'h1);
      we = 2'b01; wa0 = 5'd3; wd0 = 32'h000000AA;
      #1;
      check("sb_wb_mask_x3", busy(0), 32'h0);
      check("sb_wb_data_x3", rd0(), 32'h000000AA);
      tick();
      we = 2'b00;
      #1;
      check("sb_clr_x3", busy(0), 32'h0);

      // Issue and writeback to x3 on the same edge: issue wins
      iss_v = 1'b1; iss_a = 5'd3; we = 2'b10; wa1 = 5'd3; wd1 = 32'h000000BB;
      tick();
      iss_v = 1'b0; we = 2'b00;
      #1;
      check("sb_iss_wins_x3", busy(0), 32'h1);
      check("sb_iss_data_x3", rd0(), 32'h000000BB);

      // Busy on x4, x9, x31 then flush with a simultaneous issue to x4
      iss_v = 1'b1; iss_a = 5'd4;  tick();
      iss_a = 5'd9;                tick();
      iss_a = 5'd31;               tick();
      iss_v = 1'b0;
      ra0 = 5'd4; ra1 = 5'd9;
      #1;
      check("sb_busy_x4", busy(0), 32'h1);
      check("sb_busy_x9", busy(1), 32'h1);
      ra0 = 5'd31; ra1 = 5'd3;
      #1;
      check("sb_busy_x31", busy(0), 32'h1);
      check("sb_busy_x3", busy(1), 32'h1);
      flush = 1'b1; iss_v = 1'b1; iss_a = 5'd4;
      tick();
      flush = 1'b0; iss_v = 1'b0;
      ra0 = 5'd4; ra1 = 5'd9;
      #1;
      check("flush_x4", busy(0), 32'h0);
      check("flush_x9", busy(1), 32'h0);
      ra0 = 5'd31; ra1 = 5'd3;
      #1;
      check("flush_x31", busy(0), 32'h0);
      check("flush_x3", busy(1), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
